// File: rtl/brick_field_engine.sv
// brick_field_engine
//   Brick memory, per-pixel brick lookup, hit registration, remaining-brick
//   count and the serve/play/miss/clear/game-over flow with level and lives.
//
//   Optional feature macro: BRICK_MULTIHIT_EN
//     defined   : rows 0-1 refill to strength 3, rows 2-3 to 2, others to 1
//     undefined : every brick refills to strength 1
//
//   Ports
//     clk             pixel clock
//     reset_n         asynchronous active-low reset
//     hpos, vpos      beam position (9 bit)
//     frame_start     one-cycle pulse at start of vsync
//     ball_collide    ball overlaps main graphics, aligned to brick_present
//     ball_lost       one-cycle pulse when the ball passes the paddle row
//     serve           serve button, level-sensitive
//     brick_present   registered: beam inside a live brick cell
//     brick_gfx       registered: brick_present minus top/left mortar pixel
//     brick_strength  registered: hits remaining for the current cell
//     hit_pulse       one cycle per registered hit
//     ball_enable     ball may move
//     lives, level    game counters
//     bricks_left     live brick count
//     state           FSM state code (REFILL=0 .. OVER=5)
module brick_field_engine #(
  parameter int BRICKS_H     = 16,
  parameter int BRICKS_V     = 8,
  parameter int BRICK_W_LOG2 = 4,
  parameter int BRICK_H_LOG2 = 3,
  parameter int BRICK_X0     = 8,
  parameter int BRICK_Y0     = 64,
  parameter int START_LIVES  = 3,
  localparam int N_BRICKS    = BRICKS_H * BRICKS_V,
  localparam int BL_W        = $clog2(N_BRICKS + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [8:0]      hpos,
  input  logic [8:0]      vpos,
  input  logic            frame_start,
  input  logic            ball_collide,
  input  logic            ball_lost,
  input  logic            serve,
  output logic            brick_present,
  output logic            brick_gfx,
  output logic [1:0]      brick_strength,
  output logic            hit_pulse,
  output logic            ball_enable,
  output logic [3:0]      lives,
  output logic [3:0]      level,
  output logic [BL_W-1:0] bricks_left,
  output logic [2:0]      state
);

  localparam int IDX_W = $clog2(N_BRICKS);
  localparam int COL_W = $clog2(BRICKS_H);

`ifdef BRICK_MULTIHIT_EN
  localparam logic [1:0] STR_TOP = 2'd3;
  localparam logic [1:0] STR_MID = 2'd2;
`else
  localparam logic [1:0] STR_TOP = 2'd1;
  localparam logic [1:0] STR_MID = 2'd1;
`endif

  typedef enum logic [2:0] {
    S_REFILL = 3'd0,
    S_SERVE  = 3'd1,
    S_PLAY   = 3'd2,
    S_MISS   = 3'd3,
    S_CLEAR  = 3'd4,
    S_OVER   = 3'd5
  } state_t;

  function automatic logic [1:0] init_strength(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] row;
    row = idx >> COL_W;
    if (int'(row) < 2)      return STR_TOP;
    else if (int'(row) < 4) return STR_MID;
    else                    return 2'd1;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

  function automatic logic [3:0] sat_dec4(input logic [3:0] v);
    return (v == 4'd0) ? v : v - 4'd1;
  endfunction

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_mem [N_BRICKS];
  logic              r_present, r_gfx, r_hit_pulse, r_hit_lock;
  logic [1:0]        r_strength;
  logic [IDX_W-1:0]  r_idx, r_fill_idx;
  logic [BL_W-1:0]   r_bricks_left;
  logic [3:0]        r_lives, r_level;

  logic [8:0]        w_dx, w_dy, w_col, w_row;
  logic              w_in_field, w_lx_nz, w_ly_nz;
  logic [IDX_W-1:0]  w_idx;
  logic [1:0]        w_rd_str, w_hit_str;
  logic              w_hit, w_last_hit, w_fill_last, w_ball_en;

  // ---- lookup: beam position -> cell index (combinational) ----
  assign w_dx  = hpos - 9'(BRICK_X0);
  assign w_dy  = vpos - 9'(BRICK_Y0);
  assign w_col = w_dx >> BRICK_W_LOG2;
  assign w_row = w_dy >> BRICK_H_LOG2;
  // Compare before subtracting so positions left of / above the field never wrap in.
  assign w_in_field = (hpos >= 9'(BRICK_X0)) && (vpos >= 9'(BRICK_Y0)) &&
                      (w_col < 9'(BRICKS_H)) && (w_row < 9'(BRICKS_V));
  assign w_idx    = IDX_W'(w_row * 9'(BRICKS_H) + w_col);
  assign w_lx_nz  = (w_dx & 9'((1 << BRICK_W_LOG2) - 1)) != 9'd0;
  assign w_ly_nz  = (w_dy & 9'((1 << BRICK_H_LOG2) - 1)) != 9'd0;
  assign w_rd_str = r_mem[w_idx];

  // ---- lookup registers ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_present  <= 1'b0;
      r_gfx      <= 1'b0;
      r_strength <= 2'd0;
      r_idx      <= '0;
    end else begin
      r_present  <= w_in_field && (w_rd_str != 2'd0);
      r_gfx      <= w_in_field && (w_rd_str != 2'd0) && w_lx_nz && w_ly_nz;
      r_strength <= w_in_field ? w_rd_str : 2'd0;
      r_idx      <= w_idx;
    end
  end

  // ---- hit qualification on the registered cell ----
  assign w_hit     = (r_state == S_PLAY) && ball_collide && r_present && !r_hit_lock;
  assign w_hit_str = r_mem[r_idx];
  // The hit that removes the final brick: lets CLEAR take priority over a
  // same-cycle ball_lost before bricks_left has visibly reached zero.
  assign w_last_hit = w_hit && (w_hit_str == 2'd1) && (r_bricks_left == BL_W'(1));

  // ---- brick memory (contents rebuilt by REFILL, so no reset) ----
  always_ff @(posedge clk) begin
    if (r_state == S_REFILL)
      r_mem[r_fill_idx] <= init_strength(r_fill_idx);
    else if (w_hit)
      r_mem[r_idx] <= w_hit_str - 2'd1;
  end

  // ---- FSM next state / outputs ----
  always_comb begin
    w_state_nxt = r_state;
    w_fill_last = 1'b0;
    w_ball_en   = 1'b0;
    case (r_state)
      S_REFILL: begin
        w_fill_last = (r_fill_idx == IDX_W'(N_BRICKS - 1));
        if (w_fill_last) w_state_nxt = S_SERVE;
      end
      S_SERVE: if (serve) w_state_nxt = S_PLAY;
      S_PLAY: begin
        w_ball_en = 1'b1;
        if ((r_bricks_left == '0) || w_last_hit) w_state_nxt = S_CLEAR;
        else if (ball_lost)                      w_state_nxt = S_MISS;
      end
      S_MISS:  if (frame_start) w_state_nxt = (r_lives == 4'd0) ? S_OVER : S_SERVE;
      S_CLEAR: if (frame_start) w_state_nxt = S_REFILL;
      S_OVER:  if (serve)       w_state_nxt = S_REFILL;
      default: w_state_nxt = S_REFILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_REFILL;
    else          r_state <= w_state_nxt;
  end

  // ---- hit pulse and per-frame hit lock ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_pulse <= 1'b0;
      r_hit_lock  <= 1'b0;
    end else begin
      r_hit_pulse <= w_hit;
      if (w_hit)            r_hit_lock <= 1'b1;
      else if (frame_start) r_hit_lock <= 1'b0;
    end
  end

  // ---- refill index and brick count ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fill_idx    <= '0;
      r_bricks_left <= '0;
    end else if (r_state == S_REFILL) begin
      if (w_fill_last) begin
        r_fill_idx    <= '0;
        r_bricks_left <= BL_W'(N_BRICKS);
      end else begin
        r_fill_idx <= r_fill_idx + IDX_W'(1);
      end
    end else if (w_hit && (w_hit_str == 2'd1)) begin
      r_bricks_left <= r_bricks_left - BL_W'(1);
    end
  end

  // ---- lives / level, updated on the entering transition ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lives <= 4'(START_LIVES);
      r_level <= 4'd1;
    end else begin
      if (r_state == S_PLAY && w_state_nxt == S_MISS)  r_lives <= sat_dec4(r_lives);
      if (r_state == S_PLAY && w_state_nxt == S_CLEAR) r_level <= sat_inc4(r_level);
      if (r_state == S_OVER && w_state_nxt == S_REFILL) begin
        r_lives <= 4'(START_LIVES);
        r_level <= 4'd1;
      end
    end
  end

  assign brick_present  = r_present;
  assign brick_gfx      = r_gfx;
  assign brick_strength = r_strength;
  assign hit_pulse      = r_hit_pulse;
  assign ball_enable    = w_ball_en;
  assign lives          = r_lives;
  assign level          = r_level;
  assign bricks_left    = r_bricks_left;
  assign state          = r_state;

endmodule

// File: tb/tb_brick_field_engine.sv
// Testbench for brick_field_engine (default parameters). Randomized lookups
// and hits are checked against a transaction-level game model.
module tb_brick_field_engine;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int CW = 16;
  localparam int CH = 8;
  localparam int X0 = 8;
  localparam int Y0 = 64;
  localparam int N  = H * V;
  localparam int BL_W = $clog2(N + 1);

  localparam int ST_REFILL = 0, ST_SERVE = 1, ST_PLAY = 2, ST_MISS = 3, ST_CLEAR = 4, ST_OVER = 5;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [8:0]      hpos, vpos;
  logic            frame_start, ball_collide, ball_lost, serve;
  logic            brick_present, brick_gfx, hit_pulse, ball_enable;
  logic [1:0]      brick_strength;
  logic [3:0]      lives, level;
  logic [BL_W-1:0] bricks_left;
  logic [2:0]      state;

  brick_field_engine dut (
    .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos),
    .frame_start(frame_start), .ball_collide(ball_collide),
    .ball_lost(ball_lost), .serve(serve),
    .brick_present(brick_present), .brick_gfx(brick_gfx),
    .brick_strength(brick_strength), .hit_pulse(hit_pulse),
    .ball_enable(ball_enable), .lives(lives), .level(level),
    .bricks_left(bricks_left), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  int m_str [N];
  int m_bricks, m_lives, m_level, m_state;
  bit m_lock;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int init_str(input int row);
`ifdef BRICK_MULTIHIT_EN
    if (row < 2) return 3;
    if (row < 4) return 2;
`endif
    return 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_lives = 3; m_level = 1; m_bricks = 0; m_state = ST_REFILL; m_lock = 0;
  endtask

  task automatic check_game(input string tag);
    check({tag, "_state"}, int'(state), m_state);
    check({tag, "_lives"}, int'(lives), m_lives);
    check({tag, "_level"}, int'(level), m_level);
    check({tag, "_bricks"}, int'(bricks_left), m_bricks);
    check({tag, "_ball_en"}, int'(ball_enable), (m_state == ST_PLAY) ? 1 : 0);
  endtask

  task automatic wait_refill();
    int cnt = 0;
    while (state == 3'd0 && cnt < N + 20) begin
      step();
      cnt++;
    end
    check("refill_len", cnt, N);
    for (int i = 0; i < N; i++) m_str[i] = init_str(i / H);
    m_bricks = N;
    m_state  = ST_SERVE;
    check_game("refill_done");
  endtask

  task automatic model_lookup(input int h, input int v, output int p, output int g, output int s);
    int col, row;
    p = 0; g = 0; s = 0;
    if (h >= X0 && v >= Y0) begin
      col = (h - X0) / CW;
      row = (v - Y0) / CH;
      if (col < H && row < V) begin
        s = m_str[row * H + col];
        p = (s != 0) ? 1 : 0;
        g = (p == 1 && ((h - X0) % CW) != 0 && ((v - Y0) % CH) != 0) ? 1 : 0;
      end
    end
  endtask

  task automatic look(input int h, input int v);
    int p, g, s;
    hpos = 9'(h); vpos = 9'(v);
    step();
    model_lookup(h, v, p, g, s);
    check("look_present", int'(brick_present), p);
    check("look_gfx", int'(brick_gfx), g);
    check("look_strength", int'(brick_strength), s);
  endtask

  task automatic hit_at(input int row, input int col, input bit lost);
    int h, v, p, g, s, exp_hit;
    h = X0 + col * CW + int'($urandom_range(0, CW - 1));
    v = Y0 + row * CH + int'($urandom_range(0, CH - 1));
    hpos = 9'(h); vpos = 9'(v); ball_collide = 0;
    step();
    model_lookup(h, v, p, g, s);
    check("hit_present", int'(brick_present), p);
    exp_hit = (m_state == ST_PLAY && p == 1 && !m_lock) ? 1 : 0;
    ball_collide = 1; ball_lost = lost;
    step();
    ball_collide = 0; ball_lost = 0;
    check("hit_pulse", int'(hit_pulse), exp_hit);
    if (exp_hit == 1) begin
      m_str[row * H + col]--;
      if (m_str[row * H + col] == 0) m_bricks--;
      m_lock = 1;
    end
    if (m_state == ST_PLAY) begin
      if (m_bricks == 0) begin
        m_state = ST_CLEAR;
        if (m_level < 15) m_level++;
      end else if (lost) begin
        m_state = ST_MISS;
        if (m_lives > 0) m_lives--;
      end
    end
    check_game("hit");
  endtask

  task automatic pulse_frame();
    frame_start = 1;
    step();
    frame_start = 0;
    m_lock = 0;
    if (m_state == ST_MISS)       m_state = (m_lives == 0) ? ST_OVER : ST_SERVE;
    else if (m_state == ST_CLEAR) m_state = ST_REFILL;
    check_game("frame");
  endtask

  task automatic do_lost();
    ball_lost = 1;
    step();
    ball_lost = 0;
    if (m_state == ST_PLAY) begin
      m_state = ST_MISS;
      if (m_lives > 0) m_lives--;
    end
    check_game("lost");
  endtask

  task automatic do_serve();
    serve = 1;
    step();
    serve = 0;
    if (m_state == ST_SERVE) m_state = ST_PLAY;
    else if (m_state == ST_OVER) begin
      m_state = ST_REFILL; m_lives = 3; m_level = 1;
    end
    check_game("serve");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    reset_n = 0; hpos = '0; vpos = '0;
    frame_start = 0; ball_collide = 0; ball_lost = 0; serve = 0;
    model_reset();
    repeat (3) step();
    check_game("reset");
    check("reset_hit_pulse", int'(hit_pulse), 0);
    check("reset_present", int'(brick_present), 0);
    check("reset_strength", int'(brick_strength), 0);
    reset_n = 1;
    wait_refill();

    // boundary lookups around the field edges and the mortar pixel
    look(X0 - 1, Y0);          look(X0, Y0);
    look(X0 + 1, Y0 + 1);      look(X0 + H * CW - 1, Y0 + 3);
    look(X0 + H * CW, Y0 + 3); look(X0 + 5, Y0 + V * CH - 1);
    look(X0 + 5, Y0 + V * CH); look(X0 + 5, Y0 - 1);
    look(0, 0);                look(511, 511);
    for (int i = 0; i < 30; i++)
      look(int'($urandom_range(0, 300)), int'($urandom_range(40, 150)));

    // collisions outside PLAY are ignored
    hit_at(2, 2, 0);
    do_serve();

    // single hit at row 5 col 3, then the cell reads back from the model
    hit_at(5, 3, 0);
    pulse_frame();
    look(X0 + 3 * CW + 4, Y0 + 5 * CH + 4);

    // three collisions in one frame -> one hit; next frame accepts again
    for (int i = 0; i < 3; i++) hit_at(6 + (i % 2), 4 + i, 0);
    pulse_frame();
    hit_at(7, 10, 0);

    // repeated hits on row 0 col 0 across frames
    for (int k = 0; k < 4; k++) begin
      pulse_frame();
      hit_at(0, 0, 0);
      look(X0 + 2, Y0 + 2);
    end

    // randomized play
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0: look(int'($urandom_range(0, 300)), int'($urandom_range(40, 150)));
        1: hit_at(int'($urandom_range(0, V - 1)), int'($urandom_range(0, H - 1)), 0);
        default: pulse_frame();
      endcase
    end

    // three misses -> game over
    for (int i = 0; i < 3; i++) begin
      do_lost();
      pulse_frame();
      if (m_state == ST_SERVE) do_serve();
    end
    check("over_state", int'(state), ST_OVER);

    // serve held through OVER -> REFILL -> SERVE -> PLAY
    serve = 1;
    step();
    m_state = ST_REFILL; m_lives = 3; m_level = 1;
    check_game("restart");
    wait_refill();
    step();
    serve = 0;
    m_state = ST_PLAY;
    check_game("held_serve");

    // clear every brick; the last one lands together with ball_lost
    for (int i = 0; i < N; i++) begin
      guard = 0;
      while (m_str[i] > 0 && guard < 4) begin
        pulse_frame();
        hit_at(i / H, i % H, (m_bricks == 1 && m_str[i] == 1) ? 1'b1 : 1'b0);
        guard++;
      end
    end
    check("clear_state", int'(state), ST_CLEAR);
    check("clear_lives", int'(lives), 3);
    check("clear_level", int'(level), 2);
    pulse_frame();
    wait_refill();

    // asynchronous reset in the middle of play
    do_serve();
    hit_at(int'($urandom_range(0, V - 1)), int'($urandom_range(0, H - 1)), 0);
    @(posedge clk);
    #3 reset_n = 0;
    #1;
    model_reset();
    check_game("async_rst_play");
    step();
    reset_n = 1;
    // and again part-way through REFILL: the refill restarts from index 0
    repeat (10) step();
    #2 reset_n = 0;
    #1;
    check_game("async_rst_refill");
    step();
    reset_n = 1;
    wait_refill();
    look(X0 + 1, Y0 + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
